// File: rtl/compl_div.sv
// Sequential complex divider: Q = A*conj(B) / |B|^2 using two parallel restoring
// dividers, one quotient bit per cycle, FRAC_W fractional bits, saturated to 18 bits.
//
// state | meaning
// IDLE  | waiting for operands, in_ready_o high
// PREP  | form numerators, |B|^2, signs and magnitudes
// DIV   | ITER restoring-division steps on both lanes
// FIX   | restore signs, saturate, register outputs
// DONE  | result valid, hold until out_ready_i
module compl_div #(
  parameter int FRAC_W = 8
) (
  input  logic               clk_i,
  input  logic               srst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic signed [17:0] data_a_i_i,
  input  logic signed [17:0] data_a_q_i,
  input  logic signed [17:0] data_b_i_i,
  input  logic signed [17:0] data_b_q_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic signed [17:0] data_i_o,
  output logic signed [17:0] data_q_o,
  output logic               dz_o,
  output logic               sat_o
);

  localparam int ITER = 36 + FRAC_W;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_DIV, S_FIX, S_DONE} state_t;

  state_t r_state, w_next;

  logic signed [17:0] r_ai, r_aq, r_bi, r_bq;
  logic [35:0]        r_den;
  logic [5:0]         r_cnt;
  logic               r_dz_pend;
  logic               r_neg [2];
  logic [35:0]        r_rem [2];
  logic [ITER-1:0]    r_quo [2];
  logic signed [17:0] r_res [2];
  logic               r_dz, r_sat;

  logic signed [35:0] w_p_ii, w_p_qq, w_p_qi, w_p_iq, w_p_bi, w_p_bq;
  logic signed [36:0] w_num [2];
  logic [35:0]        w_den;
  logic [35:0]        w_mag [2];
  logic [36:0]        w_trial [2];
  logic [36:0]        w_rem_nxt [2];
  logic               w_qbit [2];
  logic signed [17:0] w_res [2];
  logic               w_sat [2];

  always_ff @(posedge clk_i) begin
    if (srst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid_i) w_next = S_PREP;
      S_PREP: w_next = (w_den == 36'd0) ? S_FIX : S_DIV;
      S_DIV:  if (r_cnt == 6'(ITER - 1)) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Products are exact in 36 bits; operands are sign-extended before multiplying.
  always_comb begin
    w_p_ii   = 36'(r_ai) * 36'(r_bi);
    w_p_qq   = 36'(r_aq) * 36'(r_bq);
    w_p_qi   = 36'(r_aq) * 36'(r_bi);
    w_p_iq   = 36'(r_ai) * 36'(r_bq);
    w_p_bi   = 36'(r_bi) * 36'(r_bi);
    w_p_bq   = 36'(r_bq) * 36'(r_bq);
    w_num[0] = 37'(w_p_ii) + 37'(w_p_qq);
    w_num[1] = 37'(w_p_qi) - 37'(w_p_iq);
    w_den    = $unsigned(w_p_bi) + $unsigned(w_p_bq);
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      w_mag[k]     = w_num[k][36] ? 36'(-w_num[k]) : 36'(w_num[k]);
      w_trial[k]   = {r_rem[k], r_quo[k][ITER-1]};
      w_qbit[k]    = (w_trial[k] >= {1'b0, r_den});
      w_rem_nxt[k] = w_qbit[k] ? (w_trial[k] - {1'b0, r_den}) : w_trial[k];
      w_sat[k]     = 1'b0;
      if (!r_neg[k]) begin
        if (r_quo[k] > ITER'(131071)) begin
          w_res[k] = 18'sd131071;
          w_sat[k] = 1'b1;
        end else begin
          w_res[k] = r_quo[k][17:0];
        end
      end else begin
        if (r_quo[k] > ITER'(131072)) begin
          w_res[k] = 18'h20000;
          w_sat[k] = 1'b1;
        end else begin
          w_res[k] = -r_quo[k][17:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_ai      <= '0;
      r_aq      <= '0;
      r_bi      <= '0;
      r_bq      <= '0;
      r_den     <= '0;
      r_cnt     <= '0;
      r_dz_pend <= 1'b0;
      r_dz      <= 1'b0;
      r_sat     <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        r_neg[k] <= 1'b0;
        r_rem[k] <= '0;
        r_quo[k] <= '0;
        r_res[k] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (in_valid_i) begin
          r_ai <= data_a_i_i;
          r_aq <= data_a_q_i;
          r_bi <= data_b_i_i;
          r_bq <= data_b_q_i;
        end
        S_PREP: begin
          r_den     <= w_den;
          r_cnt     <= '0;
          r_dz_pend <= (w_den == 36'd0);
          for (int k = 0; k < 2; k++) begin
            r_neg[k] <= w_num[k][36];
            r_rem[k] <= '0;
            r_quo[k] <= ITER'(w_mag[k]) << FRAC_W;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + 6'd1;
          // Dividend bits shift out of the top while quotient bits fill the bottom.
          for (int k = 0; k < 2; k++) begin
            r_rem[k] <= 36'(w_rem_nxt[k]);
            r_quo[k] <= {r_quo[k][ITER-2:0], w_qbit[k]};
          end
        end
        S_FIX: begin
          r_dz <= r_dz_pend;
          if (r_dz_pend) begin
            r_res[0] <= '0;
            r_res[1] <= '0;
            r_sat    <= 1'b0;
          end else begin
            r_res[0] <= w_res[0];
            r_res[1] <= w_res[1];
            r_sat    <= w_sat[0] | w_sat[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign data_i_o    = r_res[0];
  assign data_q_o    = r_res[1];
  assign dz_o        = r_dz;
  assign sat_o       = r_sat;

endmodule

// File: tb/tb_compl_div.sv
// Scoreboard bench for compl_div: directed cases plus random operands checked
// against an arithmetic reference of trunc(A*conj(B)*2^FW/|B|^2) with saturation.
module tb_compl_div;
  localparam int FW = 8;

  logic               clk = 1'b0;
  logic               srst_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic signed [17:0] data_a_i_i, data_a_q_i, data_b_i_i, data_b_q_i;
  logic signed [17:0] data_i_o, data_q_o;
  logic               dz_o, sat_o;

  always #5 clk = ~clk;

  compl_div #(.FRAC_W(FW)) dut (
    .clk_i(clk), .srst_i(srst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .data_a_i_i(data_a_i_i), .data_a_q_i(data_a_q_i),
    .data_b_i_i(data_b_i_i), .data_b_q_i(data_b_q_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .data_i_o(data_i_o), .data_q_o(data_q_o),
    .dz_o(dz_o), .sat_o(sat_o)
  );

  typedef struct {
    longint di;
    longint dq;
    longint dz;
    longint sat;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic longint clamp(input longint q, output longint s);
    s = 0;
    if (q > 131071) begin s = 1; return 131071; end
    if (q < -131072) begin s = 1; return -131072; end
    return q;
  endfunction

  function automatic exp_t model(input longint ai, aq, bi, bq);
    exp_t   e;
    longint den, si, sq;
    den = bi * bi + bq * bq;
    if (den == 0) begin
      e.di = 0; e.dq = 0; e.dz = 1; e.sat = 0;
      return e;
    end
    // SV signed integer division truncates toward zero.
    e.di  = clamp(((ai * bi + aq * bq) * (64'sd1 <<< FW)) / den, si);
    e.dq  = clamp(((aq * bi - ai * bq) * (64'sd1 <<< FW)) / den, sq);
    e.dz  = 0;
    e.sat = (si != 0 || sq != 0) ? 1 : 0;
    return e;
  endfunction

  function automatic longint rs18();
    logic [17:0] v;
    v = 18'($urandom);
    return longint'($signed(v));
  endfunction

  always @(negedge clk) begin
    if (!srst_i && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_i", longint'(data_i_o), e.di);
        chk("data_q", longint'(data_q_o), e.dq);
        chk("dz", longint'(dz_o), e.dz);
        chk("sat", longint'(sat_o), e.sat);
      end
    end
  end

  task automatic issue(input longint ai, aq, bi, bq, input bit push, output int acc);
    int w;
    w = 0;
    while (!in_ready_o && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 500) chk("in_ready_timeout", 0, 1);
    data_a_i_i = 18'(ai);
    data_a_q_i = 18'(aq);
    data_b_i_i = 18'(bi);
    data_b_q_i = 18'(bq);
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    in_valid_i = 1'b0;
    if (push) sb.push_back(model(ai, aq, bi, bq));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0, acc1, lat, late;
    longint ai, aq, bi, bq;

    srst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    data_a_i_i = '0; data_a_q_i = '0; data_b_i_i = '0; data_b_q_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_data_i", data_i_o, 0);
    chk("rst_data_q", data_q_o, 0);
    chk("rst_dz", dz_o, 0);
    chk("rst_sat", sat_o, 0);
    srst_i = 1'b0;

    issue(3, 4, 1, 2, 1, acc0);
    wait_valid(lat);
    chk("latency_normal", lat, 46);
    issue(1, 1, 1, 1, 1, acc0);
    issue(5, -7, 0, 0, 1, acc1);
    chk("throughput", acc1 - acc0, 48);
    wait_valid(lat);
    chk("latency_dz", lat, 2);
    issue(131071, 0, 1, 0, 1, acc0);
    issue(-131072, 0, 1, 0, 1, acc0);
    wait_valid(lat);
    @(posedge clk); #1;

    // Backpressure: result must hold and new operands must be ignored.
    out_ready_i = 1'b0;
    issue(3, 4, 1, 2, 1, acc0);
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      in_valid_i = i[0];
      data_a_i_i = 18'($urandom); data_b_i_i = 18'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid_o, 1);
      chk("bp_in_ready", in_ready_o, 0);
      chk("bp_data_i", data_i_o, 563);
      chk("bp_data_q", data_q_o, -102);
      chk("bp_flags", {dz_o, sat_o}, 0);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready_o, 1);
    chk("bp_release_out_valid", out_valid_o, 0);
    chk("bp_hold_data_i", data_i_o, 563);

    // Reset in the middle of DIV (iteration 20) discards the operation.
    issue(3, 4, 1, 2, 0, acc0);
    repeat (21) @(posedge clk);
    #1;
    srst_i = 1'b1;
    @(posedge clk); #1;
    srst_i = 1'b0;
    chk("midrst_in_ready", in_ready_o, 1);
    chk("midrst_out_valid", out_valid_o, 0);
    chk("midrst_data_i", data_i_o, 0);
    chk("midrst_data_q", data_q_o, 0);
    chk("midrst_flags", {dz_o, sat_o}, 0);
    late = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (out_valid_o) late++;
    end
    chk("midrst_no_late_output", late, 0);
    issue(3, 4, 1, 2, 1, acc0);
    wait_valid(lat);
    chk("latency_after_rst", lat, 46);

    for (int n = 0; n < 1000; n++) begin
      ai = rs18(); aq = rs18();
      if ($urandom_range(0, 3) == 0) begin
        bi = longint'($urandom_range(0, 8)) - 4;
        bq = longint'($urandom_range(0, 8)) - 4;
      end else begin
        bi = rs18(); bq = rs18();
      end
      if (bi == 0 && bq == 0) bi = 1;
      issue(ai, aq, bi, bq, 1, acc0);
      wait_valid(lat);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
